// File: rtl/mpt_pkg.sv
// Shared MPT walker types.
// Default-width views of the forwarding cache entry and result.
package mpt_pkg;

  localparam int MPT_FWD_DEPTH = 32;
  localparam int MPT_TAG_W     = 34;
  localparam int MPT_DATA_W    = 64;
  localparam int MPT_SIDE_W    = 32;
  localparam int MPT_CNT_W     = 32;

  typedef struct packed {
    logic                  valid;
    logic [MPT_TAG_W-1:0]  tag;
    logic [MPT_DATA_W-1:0] data;
  } mpte_fwd_cache_entry_t;

  typedef struct packed {
    logic                  hit;
    logic [MPT_TAG_W-1:0]  tag;
    logic [MPT_DATA_W-1:0] data;
    logic [MPT_SIDE_W-1:0] side;
  } mpte_fwd_cache_res_t;

endpackage

// File: rtl/fwd_cache_first_set.sv
// Lowest-set-bit encoder.
// idx_o is zero when no bit is set; qualify with found_o.
module fwd_cache_first_set #(
  parameter  int WIDTH = 8,
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IW-1:0]    idx_o,
  output logic             found_o
);

  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

  assign found_o = |vec_i;

endmodule

// File: rtl/mpte_forwarding_cache.sv
// Fully associative MPTE forwarding cache between
// MPTE parsing and the memory stage.
module mpte_forwarding_cache
  import mpt_pkg::*;
#(
  parameter int DEPTH          = MPT_FWD_DEPTH,
  parameter int TAG_WIDTH      = MPT_TAG_W,
  parameter int DATA_WIDTH     = MPT_DATA_W,
  parameter int SIDEBAND_WIDTH = MPT_SIDE_W,
  parameter int CNT_WIDTH      = MPT_CNT_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      lkp_valid_i,
  output logic                      lkp_ready_o,
  input  logic                      lkp_walk_i,
  input  logic [TAG_WIDTH-1:0]      lkp_tag_i,
  input  logic [DATA_WIDTH-1:0]     lkp_data_i,
  input  logic [SIDEBAND_WIDTH-1:0] lkp_side_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic                      res_hit_o,
  output logic [TAG_WIDTH-1:0]      res_tag_o,
  output logic [DATA_WIDTH-1:0]     res_data_o,
  output logic [SIDEBAND_WIDTH-1:0] res_side_o,
  input  logic                      upd_valid_i,
  input  logic [TAG_WIDTH-1:0]      upd_tag_i,
  input  logic [DATA_WIDTH-1:0]     upd_data_i,
  output logic [CNT_WIDTH-1:0]      hit_cnt_o,
  output logic [CNT_WIDTH-1:0]      miss_cnt_o
);

  localparam int IW = $clog2(DEPTH);
  typedef logic [IW-1:0] idx_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef struct packed {
    logic                      hit;
    logic [TAG_WIDTH-1:0]      tag;
    logic [DATA_WIDTH-1:0]     data;
    logic [SIDEBAND_WIDTH-1:0] side;
  } res_t;

  entry_t               ent_q [DEPTH];
  res_t                 res_q;
  res_t                 res_d;
  logic                 res_valid_q;
  idx_t                 victim_q;
  logic [CNT_WIDTH-1:0] hit_cnt_q;
  logic [CNT_WIDTH-1:0] miss_cnt_q;

  logic [DEPTH-1:0] match_m;
  logic [DEPTH-1:0] free_m;
  logic [DEPTH-1:0] upd_m;
  idx_t             match_idx;
  idx_t             free_idx;
  logic             match_found;
  logic             free_found;
  logic             lkp_acc;
  logic             bypass;
  logic             lkp_hit;

  always_comb begin
    match_m = '0;
    free_m  = '0;
    upd_m   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_m[i] = ent_q[i].valid && (ent_q[i].tag == lkp_tag_i);
      upd_m[i]   = ent_q[i].valid && (ent_q[i].tag == upd_tag_i);
      free_m[i]  = !ent_q[i].valid;
    end
  end

  fwd_cache_first_set #(.WIDTH(DEPTH)) u_match_enc (
    .vec_i   (match_m),
    .idx_o   (match_idx),
    .found_o (match_found)
  );

  fwd_cache_first_set #(.WIDTH(DEPTH)) u_free_enc (
    .vec_i   (free_m),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  assign lkp_ready_o = !res_valid_q || res_ready_i;
  assign lkp_acc     = lkp_valid_i && lkp_ready_o;
  assign bypass      = upd_valid_i && (upd_tag_i == lkp_tag_i);
  assign lkp_hit     = lkp_walk_i && !flush_i
                     && (bypass || match_found);

  // The in-flight write-back is fresher than the array copy.
  always_comb begin
    res_d      = '0;
    res_d.hit  = lkp_hit;
    res_d.tag  = lkp_tag_i;
    res_d.side = lkp_side_i;
    res_d.data = lkp_data_i;
    if (lkp_hit) begin
      res_d.data = bypass ? upd_data_i : ent_q[match_idx].data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else if (lkp_ready_o) begin
      res_valid_q <= lkp_valid_i;
      if (lkp_acc) res_q <= res_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (lkp_acc && lkp_walk_i) begin
      if (lkp_hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  // Valid tags are unique, so a refresh touches at most one entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      victim_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else if (upd_valid_i) begin
      if (|upd_m) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (upd_m[i]) ent_q[i].data <= upd_data_i;
        end
      end else if (free_found) begin
        ent_q[free_idx] <= '{valid: 1'b1, tag: upd_tag_i,
                             data: upd_data_i};
      end else begin
        ent_q[victim_q] <= '{valid: 1'b1, tag: upd_tag_i,
                             data: upd_data_i};
        victim_q <= (victim_q == idx_t'(DEPTH - 1))
                  ? '0 : victim_q + 1'b1;
      end
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_hit_o   = res_q.hit;
  assign res_tag_o   = res_q.tag;
  assign res_data_o  = res_q.data;
  assign res_side_o  = res_q.side;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_mpte_forwarding_cache.sv
// Bench for mpte_forwarding_cache: directed steps plus
// random traffic against a slot-level reference model.
module tb_mpte_forwarding_cache;

  localparam int DEPTH = 5;
  localparam int TW    = 12;
  localparam int DW    = 16;
  localparam int SW    = 8;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          lkp_valid;
  logic          lkp_ready;
  logic          lkp_walk;
  logic [TW-1:0] lkp_tag;
  logic [DW-1:0] lkp_data;
  logic [SW-1:0] lkp_side;
  logic          res_valid;
  logic          res_ready;
  logic          res_hit;
  logic [TW-1:0] res_tag;
  logic [DW-1:0] res_data;
  logic [SW-1:0] res_side;
  logic          upd_valid;
  logic [TW-1:0] upd_tag;
  logic [DW-1:0] upd_data;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  always #5 clk = ~clk;

  mpte_forwarding_cache #(
    .DEPTH          (DEPTH),
    .TAG_WIDTH      (TW),
    .DATA_WIDTH     (DW),
    .SIDEBAND_WIDTH (SW),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .lkp_valid_i (lkp_valid),
    .lkp_ready_o (lkp_ready),
    .lkp_walk_i  (lkp_walk),
    .lkp_tag_i   (lkp_tag),
    .lkp_data_i  (lkp_data),
    .lkp_side_i  (lkp_side),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_hit_o   (res_hit),
    .res_tag_o   (res_tag),
    .res_data_o  (res_data),
    .res_side_o  (res_side),
    .upd_valid_i (upd_valid),
    .upd_tag_i   (upd_tag),
    .upd_data_i  (upd_data),
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
  );

  int tests = 0;
  int fails = 0;

  bit            m_v [DEPTH];
  logic [TW-1:0] m_t [DEPTH];
  logic [DW-1:0] m_d [DEPTH];
  int            m_vic;
  bit            m_rv;
  bit            m_hit;
  logic [TW-1:0] m_rt;
  logic [DW-1:0] m_rd;
  logic [SW-1:0] m_rs;
  int            m_hc;
  int            m_mc;

  task automatic chk(input string name,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             name, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 0;
      m_t[i] = '0;
      m_d[i] = '0;
    end
    m_vic = 0;
    m_rv  = 0;
    m_hit = 0;
    m_rt  = '0;
    m_rd  = '0;
    m_rs  = '0;
    m_hc  = 0;
    m_mc  = 0;
  endtask

  function automatic bit mdl_find(input logic [TW-1:0] t,
                                  output int idx);
    idx = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_v[i] && m_t[i] == t) idx = i;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_v[i] && m_t[i] == t) return 1;
    end
    return 0;
  endfunction

  task automatic mdl_write(input logic [TW-1:0] t,
                           input logic [DW-1:0] d);
    int k;
    if (mdl_find(t, k)) begin
      m_d[k] = d;
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_v[i]) begin
        m_v[i] = 1;
        m_t[i] = t;
        m_d[i] = d;
        return;
      end
    end
    m_t[m_vic] = t;
    m_d[m_vic] = d;
    m_vic = (m_vic + 1) % DEPTH;
  endtask

  task automatic check_outputs();
    chk("res_valid", res_valid, m_rv);
    chk("res_hit",   res_hit,   m_hit);
    chk("res_tag",   res_tag,   m_rt);
    chk("res_data",  res_data,  m_rd);
    chk("res_side",  res_side,  m_rs);
    chk("hit_cnt",   hit_cnt,   m_hc);
    chk("miss_cnt",  miss_cnt,  m_mc);
  endtask

  // One clock: inputs must already be driven.
  task automatic step();
    bit            rdy;
    bit            acc;
    bit            h;
    logic [DW-1:0] d;
    int            k;
    #1;
    rdy = !m_rv || res_ready;
    chk("lkp_ready", lkp_ready, rdy);
    acc = lkp_valid && rdy;
    h = 0;
    d = lkp_data;
    if (lkp_walk && !flush) begin
      if (upd_valid && upd_tag == lkp_tag) begin
        h = 1;
        d = upd_data;
      end else if (mdl_find(lkp_tag, k)) begin
        h = 1;
        d = m_d[k];
      end
    end
    @(posedge clk);
    if (rdy) m_rv = lkp_valid;
    if (acc) begin
      m_hit = h;
      m_rt  = lkp_tag;
      m_rd  = d;
      m_rs  = lkp_side;
      if (lkp_walk) begin
        if (h) m_hc = (m_hc < CMAX) ? m_hc + 1 : CMAX;
        else   m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
      end
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
    end else if (upd_valid) begin
      mdl_write(upd_tag, upd_data);
    end
    #1;
    check_outputs();
  endtask

  task automatic idle();
    flush     = 0;
    lkp_valid = 0;
    lkp_walk  = 0;
    upd_valid = 0;
    res_ready = 1;
  endtask

  task automatic lkp(input logic [TW-1:0] t,
                     input logic [DW-1:0] d,
                     input bit w);
    lkp_valid = 1;
    lkp_walk  = w;
    lkp_tag   = t;
    lkp_data  = d;
    lkp_side  = SW'($urandom);
  endtask

  task automatic upd(input logic [TW-1:0] t,
                     input logic [DW-1:0] d);
    upd_valid = 1;
    upd_tag   = t;
    upd_data  = d;
  endtask

  logic [DW-1:0] held;
  int            guard;

  initial begin
    rst = 1;
    idle();
    lkp_tag  = '0;
    lkp_data = '0;
    lkp_side = '0;
    upd_tag  = '0;
    upd_data = '0;
    mdl_reset();
    #12;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data",  res_data,  0);
    chk("rst_hit_cnt",   hit_cnt,   0);
    chk("rst_miss_cnt",  miss_cnt,  0);
    rst = 0;

    // First miss forwards lookup data
    lkp('h10, 'hAA, 1);
    step();
    chk("t1_valid", res_valid, 1);
    chk("t1_hit",   res_hit,   0);
    chk("t1_data",  res_data,  'hAA);
    chk("t1_miss",  miss_cnt,  1);

    idle();
    upd('h10, 'h55);
    step();
    idle();
    lkp('h10, 'hAA, 1);
    step();
    chk("t2_hit",  res_hit,  1);
    chk("t2_data", res_data, 'h55);
    chk("t2_hcnt", hit_cnt,  1);

    // Same-cycle bypass: new tag, then already-valid tag
    idle();
    upd('h20, 'h66);
    lkp('h20, 'h01, 1);
    step();
    chk("byp_new_hit",  res_hit,  1);
    chk("byp_new_data", res_data, 'h66);
    idle();
    upd('h10, 'h77);
    lkp('h10, 'h02, 1);
    step();
    chk("byp_old_data", res_data, 'h77);

    // Fill, then evict entry 0
    idle();
    upd('h30, 'h33); step();
    upd('h40, 'h44); step();
    upd('h50, 'h55); step();
    upd('h60, 'h66); step();
    idle();
    lkp('h10, 'hE0, 1);
    step();
    chk("evict_old_miss", res_hit, 0);
    lkp('h60, 'hE1, 1);
    step();
    chk("evict_new_hit",  res_hit,  1);
    chk("evict_new_data", res_data, 'h66);

    // Refresh while full must not move the victim
    idle();
    upd('h30, 'h3C); step();
    upd('h70, 'h77); step();
    idle();
    lkp('h20, 'hE2, 1);
    step();
    chk("victim_1_miss", res_hit, 0);
    lkp('h30, 'hE3, 1);
    step();
    chk("refresh_hit",  res_hit,  1);
    chk("refresh_data", res_data, 'h3C);

    // Backpressure for 5 cycles
    idle();
    lkp('h40, 'hB0, 1);
    step();
    held = m_rd;
    res_ready = 0;
    for (int i = 0; i < 5; i++) begin
      lkp(TW'('h41 + i), DW'('hB1 + i), 1);
      step();
      chk("bp_ready", lkp_ready, 0);
      chk("bp_data",  res_data,  held);
    end
    res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      lkp(TW'('h50 + 'h10 * i), DW'('hC0 + i), 1);
      step();
    end

    // Flush with concurrent update and cached lookup
    idle();
    flush = 1;
    upd('h80, 'h88);
    lkp('h30, 'hF0, 1);
    step();
    chk("flush_lkp_miss", res_hit, 0);
    chk("flush_lkp_data", res_data, 'hF0);
    idle();
    lkp('h80, 'hF1, 1);
    step();
    chk("flush_upd_drop", res_hit, 0);
    lkp('h60, 'hF2, 1);
    step();
    chk("flush_all_miss", res_hit, 0);

    // Pass-through leaves counters alone
    lkp('h61, 'hF3, 0);
    step();
    chk("pass_hit", res_hit, 0);

    // Miss counter saturation
    guard = 0;
    while (m_mc < CMAX - 1 && guard < 200) begin
      lkp(TW'('hF00 + guard), 'h0, 1);
      step();
      guard++;
    end
    chk("sat_pre", miss_cnt, CMAX - 1);
    lkp('hFF0, 'h0, 1); step();
    lkp('hFF1, 'h0, 1); step();
    chk("sat_hold", miss_cnt, CMAX);

    // Async reset mid-operation
    idle();
    upd('h90, 'h99);
    lkp('h90, 'h0, 1);
    step();
    #2;
    rst = 1;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_miss",  miss_cnt,  0);
    chk("arst_hcnt",  hit_cnt,   0);
    mdl_reset();
    rst = 0;
    idle();
    lkp('h90, 'h12, 1);
    step();
    chk("arst_entry_gone", res_hit, 0);

    // Random traffic over a small tag space
    for (int n = 0; n < 400; n++) begin
      flush     = ($urandom_range(0, 39) == 0);
      lkp_valid = ($urandom_range(0, 3) != 0);
      lkp_walk  = ($urandom_range(0, 3) != 0);
      lkp_tag   = TW'($urandom_range(0, 7));
      lkp_data  = DW'($urandom);
      lkp_side  = SW'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      upd_valid = ($urandom_range(0, 2) == 0);
      upd_tag   = TW'($urandom_range(0, 7));
      upd_data  = DW'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
